// File: rtl/acc_time_ctrl_v3_pkg.sv
// acc_time_pkg: shared constants and helpers for acc_time_ctrl_v3.
package acc_time_pkg;

   localparam int DEPTH_DEF      = 32768;
   localparam int HOLD_W_DEF     = 16;
   localparam int HOLD_UNIT_CLK  = 0;
   localparam int HOLD_UNIT_FLAG = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/acc_time_ctrl_v3_hold.sv
// acc_hold_unit: one channel's fall detect, hold stretch and output OR.
// Optional ACC_EVT_CNT_EN adds a saturating rising-edge event counter.
module acc_hold_unit
   import acc_time_pkg::*;
#(
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              tick_i,
   input  logic              cache_i,
   input  logic              dout_i,
   input  logic [HOLD_W-1:0] hold_i,
`ifdef ACC_EVT_CNT_EN
   input  logic              evt_clr_i,
   output logic [15:0]       evt_cnt_o,
`endif
   output logic              flag_o
);

   logic              r_flag;
   logic [HOLD_W-1:0] r_cnt;
   logic              w_fall;
   logic              w_zero;
   logic              w_last;

   assign w_fall = cache_i & ~dout_i;
   assign w_zero = (hold_i == '0);
   // >= so a hold shortened mid-stretch still ends on the next tick
   assign w_last = (r_cnt >= hold_i - HOLD_W'(1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_flag <= 1'b0;
         r_cnt  <= '0;
      end else if (w_zero) begin
         r_flag <= 1'b0;
      end else if (w_fall) begin
         r_flag <= 1'b1;
         r_cnt  <= '0;
      end else if (r_flag && tick_i) begin
         if (w_last) r_flag <= 1'b0;
         else        r_cnt  <= r_cnt + HOLD_W'(1);
      end
   end

   assign flag_o = cache_i | r_flag;

`ifdef ACC_EVT_CNT_EN
   logic        r_prev;
   logic [15:0] r_evt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_prev <= 1'b0;
         r_evt  <= '0;
      end else begin
         r_prev <= flag_o;
         if (evt_clr_i)
            r_evt <= '0;
         else if (flag_o && !r_prev && (r_evt != 16'hFFFF))
            r_evt <= r_evt + 16'd1;
      end
   end

   assign evt_cnt_o = r_evt;
`endif

endmodule

// File: rtl/acc_time_ctrl_v3.sv
// acc_time_ctrl_v3: multi-channel result delay line with per-channel hold stretch.
// Define ACC_EVT_CNT_EN to add evt_clr_i / evt_cnt_o rising-edge counters.
module acc_time_ctrl_v3
   import acc_time_pkg::*;
#(
   parameter int CH        = 4,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int HOLD_W    = HOLD_W_DEF,
   parameter int HOLD_UNIT = HOLD_UNIT_CLK
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 filter_unit_flag_i,
   input  logic [CH-1:0]        filter_acc_result_i,
   input  logic [15:0]          acc_delay_i,
   input  logic [CH*HOLD_W-1:0] acc_hold_i,
`ifdef ACC_EVT_CNT_EN
   input  logic                 evt_clr_i,
   output logic [CH*16-1:0]     evt_cnt_o,
`endif
   output logic [CH-1:0]        filter_acc_flag_o
);

   localparam int AW = clog2(DEPTH);

   logic [AW-1:0] r_waddr;
   logic [AW-1:0] r_fill;
   logic [AW-1:0] w_deff;
   logic [AW-1:0] w_raddr;
   logic [31:0]   w_dly;
   logic          r_valid;
   logic [CH-1:0] r_mem [DEPTH];
   logic [CH-1:0] r_ram_q;
   logic [CH-1:0] w_dout;
   logic [CH-1:0] r_cache;
   logic          w_tick;

   assign w_dly = {16'd0, acc_delay_i};

   always_comb begin
      w_deff = AW'(w_dly);
      if (w_dly == 32'd0)
         w_deff = AW'(1);
      else if (w_dly > 32'(DEPTH - 1))
         w_deff = AW'(DEPTH - 1);
   end

   assign w_raddr = r_waddr - w_deff;

   // Read-first RAM; contents deliberately left unreset
   always_ff @(posedge clk_i) begin
      if (filter_unit_flag_i)
         r_mem[r_waddr] <= filter_acc_result_i;
      r_ram_q <= r_mem[w_raddr];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_waddr <= '0;
         r_fill  <= '0;
         r_valid <= 1'b0;
         r_cache <= '0;
      end else begin
         if (filter_unit_flag_i) begin
            r_waddr <= r_waddr + AW'(1);
            if (r_fill != AW'(DEPTH - 1))
               r_fill <= r_fill + AW'(1);
         end
         r_valid <= (r_fill >= w_deff);
         r_cache <= w_dout;
      end
   end

   // Words not yet written since reset read as zero
   assign w_dout = r_ram_q & {CH{r_valid}};

   assign w_tick = (HOLD_UNIT == HOLD_UNIT_FLAG) ? filter_unit_flag_i : 1'b1;

   for (genvar g = 0; g < CH; g++) begin : g_ch
      acc_hold_unit #(
         .HOLD_W (HOLD_W)
      ) u_hold (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
         .tick_i    (w_tick),
         .cache_i   (r_cache[g]),
         .dout_i    (w_dout[g]),
         .hold_i    (acc_hold_i[g*HOLD_W +: HOLD_W]),
`ifdef ACC_EVT_CNT_EN
         .evt_clr_i (evt_clr_i),
         .evt_cnt_o (evt_cnt_o[g*16 +: 16]),
`endif
         .flag_o    (filter_acc_flag_o[g])
      );
   end

endmodule
